// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule.
// Takes a cipher key (walks the forward schedule to round 10 first) or a
// round-10 key, then streams round keys 10 down to 0 over a valid/ready
// handshake. One S-box word (four byte lookups) is shared by both directions.
module inv_key_schedule #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_BITS   = 128
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                startValid,
  output logic                startReady,
  input  logic                keyIsLast,
  input  logic [KEY_BITS-1:0] keyIn,
  output logic                outValid,
  input  logic                outReady,
  output logic [KEY_BITS-1:0] roundKey,
  output logic [3:0]          roundIdx,
  output logic                outLast
);

  // Index of the final round key; only 10 (AES-128) is meaningful.
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    EMIT
  } state_t;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [3:0]   idx_reg, idx_next;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sbox_in, rot_word, sub_word, mix_word;
  logic [3:0]   rcon_idx;
  logic [127:0] fwd_key, inv_key;
  logic [31:0]  fwd0, fwd1, fwd2, fwd3;
  logic [31:0]  inv0, inv1, inv2, inv3;

  // Table index 255-b is simply ~b for an 8-bit byte.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // Forward steps substitute the current w3; inverse steps need the
  // already-recovered previous w3, which is w3^w2.
  assign sbox_in  = (state_reg == EMIT) ? (w3 ^ w2) : w3;
  assign rcon_idx = (state_reg == EMIT) ? idx_reg : idx_reg + 4'd1;
  assign rot_word = {sbox_in[23:0], sbox_in[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub_word[gi*8 +: 8] = sbox_byte(rot_word[gi*8 +: 8]);
  end

  assign mix_word = sub_word ^ {rcon(rcon_idx), 24'h000000};

  assign fwd0    = w0 ^ mix_word;
  assign fwd1    = w1 ^ fwd0;
  assign fwd2    = w2 ^ fwd1;
  assign fwd3    = w3 ^ fwd2;
  assign fwd_key = {fwd0, fwd1, fwd2, fwd3};

  assign inv3    = w3 ^ w2;
  assign inv2    = w2 ^ w1;
  assign inv1    = w1 ^ w0;
  assign inv0    = w0 ^ mix_word;
  assign inv_key = {inv0, inv1, inv2, inv3};

  // Next-state logic: load, forward walk, then reverse emission.
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (startValid) begin
          key_next = keyIn;
          if (keyIsLast) begin
            idx_next   = LAST_IDX;
            state_next = EMIT;
          end else begin
            idx_next   = 4'd0;
            state_next = FWD;
          end
        end
      end
      FWD: begin
        key_next = fwd_key;
        idx_next = idx_reg + 4'd1;
        if (idx_reg + 4'd1 == LAST_IDX) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (outReady) begin
          if (idx_reg != 4'd0) begin
            key_next = inv_key;
            idx_next = idx_reg - 4'd1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, key and round-index registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      idx_reg   <= idx_next;
    end
  end

  assign startReady = (state_reg == IDLE);
  assign outValid   = (state_reg == EMIT);
  assign roundKey   = key_reg;
  assign roundIdx   = idx_reg;
  assign outLast    = (state_reg == EMIT) && (idx_reg == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: reference key expansion built from GF(2^8)
// arithmetic, directed known-answer runs plus randomized keys/backpressure.
module tb_inv_key_schedule;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         startValid = 1'b0;
  logic         startReady;
  logic         keyIsLast = 1'b0;
  logic [127:0] keyIn = '0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         outLast;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  inv_key_schedule #(.NUM_ROUNDS(10), .KEY_BITS(128)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .startValid (startValid),
    .startReady (startReady),
    .keyIsLast  (keyIsLast),
    .keyIn      (keyIn),
    .outValid   (outValid),
    .outReady   (outReady),
    .roundKey   (roundKey),
    .roundIdx   (roundIdx),
    .outLast    (outLast)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v = 8'(a);
      logic [7:0] inv = 8'h00;
      if (v != 8'h00) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook AES-128 key expansion into eleven round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Start handshake, then measure cycles until the first valid key.
  task automatic start_key(input logic [127:0] k, input logic last, input bit pulse);
    int lat;
    @(negedge clock);
    chk("start_ready_idle", 128'(startReady), 128'(1));
    keyIn = k;
    keyIsLast = last;
    startValid = 1'b1;
    @(negedge clock);
    startValid = 1'b0;
    keyIn = {$urandom(), $urandom(), $urandom(), $urandom()};
    keyIsLast = ~last;
    lat = 1;
    while (!outValid && lat < 40) begin
      chk("start_ready_fwd", 128'(startReady), 128'(0));
      if (pulse) startValid = 1'($urandom_range(0, 1));
      @(negedge clock);
      lat++;
    end
    startValid = 1'b0;
    chk("first_latency", 128'(lat), last ? 128'(1) : 128'(11));
  endtask

  // Consume the key stream; abort_idx >= 0 asserts reset when that index shows.
  task automatic receive(input bit rand_ready, input bit pulse, input int abort_idx);
    int exp_idx = 10;
    int guard = 0;
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0] prev_idx = '0;
    while (!done && guard < 300) begin
      chk("out_valid", 128'(outValid), 128'(1));
      chk("round_idx", 128'(roundIdx), 128'(exp_idx));
      chk("round_key", roundKey, exp_rk[exp_idx]);
      chk("out_last", 128'(outLast), 128'(exp_idx == 0));
      chk("start_ready_emit", 128'(startReady), 128'(0));
      if (stalled) begin
        chk("hold_key", roundKey, prev_key);
        chk("hold_idx", 128'(roundIdx), 128'(prev_idx));
      end
      got_rk[exp_idx] = roundKey;
      if (exp_idx == abort_idx) begin
        outReady = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 128'(outValid), 128'(0));
        chk("abort_key", roundKey, 128'(0));
        chk("abort_idx", 128'(roundIdx), 128'(0));
        chk("abort_last", 128'(outLast), 128'(0));
        chk("abort_ready", 128'(startReady), 128'(1));
        $display("reset asserted at round %0d", exp_idx);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      outReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      startValid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      stalled = !outReady;
      prev_key = roundKey;
      prev_idx = roundIdx;
      if (outReady) begin
        $display("round %0d key %h last %0b", exp_idx, roundKey, outLast);
        if (exp_idx == 0) done = 1'b1;
        else exp_idx--;
      end
      @(negedge clock);
      guard++;
    end
    startValid = 1'b0;
    chk("stream_done", 128'(done), 128'(1));
    chk("valid_after_last", 128'(outValid), 128'(0));
    chk("ready_after_last", 128'(startReady), 128'(1));
  endtask

  initial begin
    logic [127:0] rkey;
    bit mode;
    build_sbox();

    // Reset values while held and after release.
    repeat (3) @(negedge clock);
    chk("rst_valid", 128'(outValid), 128'(0));
    chk("rst_key", roundKey, 128'(0));
    chk("rst_idx", 128'(roundIdx), 128'(0));
    chk("rst_last", 128'(outLast), 128'(0));
    chk("rst_ready", 128'(startReady), 128'(1));
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_valid", 128'(outValid), 128'(0));

    // Round-10 key in, full-speed drain.
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0);
    receive(1'b0, 1'b0, -1);
    chk("kat_idx1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_idx0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Cipher key in: forward walk first, with ignored start pulses.
    start_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
    receive(1'b0, 1'b0, -1);
    chk("kat_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys, both load modes, random backpressure and start pulses.
    for (int i = 0; i < 4; i++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      mode = 1'($urandom_range(0, 1));
      expand(rkey);
      start_key(mode ? exp_rk[10] : rkey, mode, 1'b1);
      receive(1'b1, 1'b1, -1);
    end

    // Reset mid-stream at round 5, then a clean full run.
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    start_key(exp_rk[10], 1'b1, 1'b0);
    receive(1'b1, 1'b0, 5);
    start_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0);
    receive(1'b1, 1'b1, -1);

    // All-zero cipher key.
    expand(128'h0);
    start_key(128'h0, 1'b0, 1'b0);
    receive(1'b0, 1'b0, -1);
    chk("zero_idx10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_idx0", got_rk[0], 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
